vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Parametrised multi-product vending controller, the successor to the single-item Rs.15 machine. It accepts coins (Rs.5/10/20) into a credit register and lets the user select one of NUM_PRODUCTS items with run-time programmable prices. It issues a vend request with a ready/valid handshake, then returns change one coin per handshake using greedy denomination selection. It sits between the coin-acceptor/keypad front end and the dispenser/hopper back end.

Parameters:
NUM_PRODUCTS, 4, number of selectable products (>=2)
CREDIT_W, 8, credit/price width in Rs.5 units
MAX_CREDIT, 40, credit ceiling in Rs.5 units (Rs.200); must be < 2**CREDIT_W

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
coin_valid  input  1  coin present this cycle (single-cycle pulse)
coin_val  input  2  01=Rs.5, 10=Rs.10, 11=Rs.20, 00=invalid coin
sel_valid  input  1  product selection pulse
sel_id  input  $clog2(NUM_PRODUCTS)  selected product index
cancel  input  1  refund request pulse
prices  input  NUM_PRODUCTS*CREDIT_W  price table in Rs.5 units; entry i at bits [i*CREDIT_W +: CREDIT_W]
vend_valid  output  1  dispense request
vend_id  output  $clog2(NUM_PRODUCTS)  product to dispense
vend_ready  input  1  dispenser accepts
chg_valid  output  1  change coin request
chg_coin  output  2  coin to return, same encoding as coin_val
chg_ready  input  1  hopper accepts coin
credit  output  CREDIT_W  current credit in Rs.5 units
coin_reject  output  1  one-cycle pulse: coin returned unaccepted
sel_denied  output  1  one-cycle pulse: selection ignored
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset: sync, active-high, clk only. state=IDLE; credit=0; vend_valid=0, vend_id=0, chg_valid=0, chg_coin=0, coin_reject=0, sel_denied=0, busy=0. Reset mid-vend or mid-change drops owed change (hardware makes no recovery).
- All outputs are registered; responses appear the cycle after the triggering input.
- Coin weight w: 01->1, 10->2, 11->4.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, CHANGE.
- IDLE/COLLECT, per-cycle priority is cancel > select > coin:
  - cancel: credit>0 -> CHANGE; credit==0 -> no-op.
  - sel_valid: sel_id>=NUM_PRODUCTS, or credit<prices[sel_id] -> sel_denied pulse, no state change. Otherwise credit -= price, vend_id=sel_id, vend_valid=1 -> VEND. A price of 0 is legal (free vend).
  - coin_valid: coin_val==00, or credit+w>MAX_CREDIT -> coin_reject pulse. Otherwise credit += w; IDLE->COLLECT.
  - A coin arriving in the same cycle as an accepted cancel or select is rejected (coin_reject=1).
- VEND: vend_valid and vend_id held stable until vend_ready. On the handshake cycle vend_valid drops next cycle; go to CHANGE if credit>0, else IDLE.
- CHANGE: chg_coin is the greedy largest coin with weight <= credit (4, then 2, then 1). chg_valid is held with chg_coin stable until chg_ready. On handshake credit -= weight; credit reaching 0 -> IDLE with chg_valid low the next cycle; otherwise present the next coin on the following cycle (one coin per handshake, at most one per 2 cycles not required; back-to-back allowed).
- VEND/CHANGE: coin_valid -> coin_reject; sel_valid -> sel_denied; cancel ignored.
- prices is sampled only at the selection cycle; changes at other times have no effect.
- Arithmetic is CREDIT_W-bit unsigned. Overflow is impossible given the MAX_CREDIT check; the credit+w sum is computed at CREDIT_W+1 bits.

Decomposition:
- vend_pkg: coin encoding constants (COIN_NONE/5/10/20), coin-weight function, state enum (IDLE, COLLECT, VEND, CHANGE).
- Sub-module vend_change_unit: greedy coin chooser plus the chg_valid/chg_ready handshake. It takes a load pulse and amount, and returns done plus a decrement. The top level owns credit and the FSM.

Test Plan:
- Prices {3,4,6,2}; insert 10,5 (credit=3); select 0 -> vend_valid, vend_id=0 next cycle; vend_ready -> IDLE, credit=0, no change coins.
- Insert 20,20 (credit=8); select 2 (price 6) -> vend, then change: one Rs.10 (chg_coin=10); with chg_ready held low 5 cycles chg_valid/chg_coin stay stable.
- Insert 5,10,20 (credit=7); cancel -> change sequence Rs.20, Rs.10, Rs.5, then IDLE, credit=0.
- Credit=2, select 1 (price 4) -> sel_denied pulse, credit stays 2; sel_id=3 with price 2 -> vend accepted.
- Credit=38, insert Rs.20 -> coin_reject, credit=38; insert Rs.10 -> credit=40; coin_val=00 -> coin_reject.
- Same-cycle cancel+sel+coin with credit=5 -> CHANGE, coin_reject=1, no vend. Assert rst during CHANGE -> all outputs 0 next cycle, credit=0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin encoding, coin weights and FSM state type for the vending controller.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  // Value of a coin in Rs.5 units; an invalid coin is worth nothing.
  function automatic logic [2:0] coin_weight(input logic [1:0] coin);
    case (coin)
      COIN_5:  coin_weight = 3'd1;
      COIN_10: coin_weight = 3'd2;
      COIN_20: coin_weight = 3'd4;
      default: coin_weight = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Pays out a loaded amount one coin per chg_valid/chg_ready handshake, largest coin first.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] amount,
  input  logic                chg_ready,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] dec,
  output logic                done
);

  logic [CREDIT_W-1:0] remaining;
  logic [CREDIT_W-1:0] rem_next;
  logic                handshake;

  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= CREDIT_W'(4))      greedy_coin = COIN_20;
    else if (amt >= CREDIT_W'(2)) greedy_coin = COIN_10;
    else                          greedy_coin = COIN_5;
  endfunction

  assign handshake = chg_valid && chg_ready;
  assign dec       = handshake ? CREDIT_W'(coin_weight(chg_coin)) : '0;
  assign done      = handshake && (remaining == dec);
  assign rem_next  = remaining - dec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_valid <= 1'b0;
      chg_coin  <= COIN_NONE;
      remaining <= '0;
    end else if (load) begin
      remaining <= amount;
      chg_coin  <= greedy_coin(amount);
      chg_valid <= 1'b1;
    end else if (handshake) begin
      remaining <= rem_next;
      if (done) begin
        chg_valid <= 1'b0;
        chg_coin  <= COIN_NONE;
      end else begin
        chg_coin  <= greedy_coin(rem_next);
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Multi-product vending controller: credit collection, priced selection, vend handshake, change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 40,
  localparam int ID_W        = $clog2(NUM_PRODUCTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           coin_valid,
  input  logic [1:0]                     coin_val,
  input  logic                           sel_valid,
  input  logic [ID_W-1:0]                sel_id,
  input  logic                           cancel,
  input  logic [NUM_PRODUCTS*CREDIT_W-1:0] prices,
  output logic                           vend_valid,
  output logic [ID_W-1:0]                vend_id,
  input  logic                           vend_ready,
  output logic                           chg_valid,
  output logic [1:0]                     chg_coin,
  input  logic                           chg_ready,
  output logic [CREDIT_W-1:0]            credit,
  output logic                           coin_reject,
  output logic                           sel_denied,
  output logic                           busy
);

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_hit;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                open;
  logic                cancel_take;
  logic                sel_take;
  logic                load_change;
  logic [CREDIT_W-1:0] chg_dec;
  logic                chg_done;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sel_price = '0;
    sel_hit   = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_price = prices[i*CREDIT_W +: CREDIT_W];
        sel_hit   = 1'b1;
      end
    end
  end

  // Sum is one bit wider than credit so the ceiling check cannot wrap.
  assign coin_sum    = {1'b0, credit} + {{(CREDIT_W-2){1'b0}}, coin_weight(coin_val)};
  assign coin_ok     = coin_valid && (coin_val != COIN_NONE) && (coin_sum <= MAX_SUM);
  assign open        = (state == IDLE) || (state == COLLECT);
  assign cancel_take = open && cancel && (credit != '0);
  assign sel_take    = open && !cancel_take && sel_valid && sel_hit && (credit >= sel_price);
  assign load_change = cancel_take || ((state == VEND) && vend_ready && (credit != '0));

  vend_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
    .clk       (clk),
    .rst       (rst),
    .load      (load_change),
    .amount    (credit),
    .chg_ready (chg_ready),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .dec       (chg_dec),
    .done      (chg_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      vend_valid  <= 1'b0;
      vend_id     <= '0;
      coin_reject <= 1'b0;
      sel_denied  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sel_denied  <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (cancel_take) begin
            state       <= CHANGE;
            busy        <= 1'b1;
            coin_reject <= coin_valid;
          end else if (sel_take) begin
            credit      <= credit - sel_price;
            vend_valid  <= 1'b1;
            vend_id     <= sel_id;
            state       <= VEND;
            busy        <= 1'b1;
            coin_reject <= coin_valid;
          end else begin
            sel_denied <= sel_valid;
            if (coin_ok) begin
              credit <= coin_sum[CREDIT_W-1:0];
              state  <= COLLECT;
            end else begin
              coin_reject <= coin_valid;
            end
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          sel_denied  <= sel_valid;
          if (vend_ready) begin
            vend_valid <= 1'b0;
            if (credit != '0) begin
              state <= CHANGE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          sel_denied  <= sel_valid;
          credit      <= credit - chg_dec;
          if (chg_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller with hand-computed expectations.
module tb_vend_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_valid;
  logic [1:0]  coin_val;
  logic        sel_valid;
  logic [1:0]  sel_id;
  logic        cancel;
  logic [31:0] prices;
  logic        vend_valid;
  logic [1:0]  vend_id;
  logic        vend_ready;
  logic        chg_valid;
  logic [1:0]  chg_coin;
  logic        chg_ready;
  logic [7:0]  credit;
  logic        coin_reject;
  logic        sel_denied;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_controller dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .cancel      (cancel),
    .prices      (prices),
    .vend_valid  (vend_valid),
    .vend_id     (vend_id),
    .vend_ready  (vend_ready),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .chg_ready   (chg_ready),
    .credit      (credit),
    .coin_reject (coin_reject),
    .sel_denied  (sel_denied),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    tick();
    coin_valid = 1'b0;
    coin_val   = 2'b00;
  endtask

  task automatic select(input logic [1:0] id);
    sel_valid = 1'b1;
    sel_id    = id;
    tick();
    sel_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; coin_valid = 0; coin_val = 0; sel_valid = 0; sel_id = 0;
    cancel = 0; vend_ready = 0; chg_ready = 0;
    prices = {8'd2, 8'd6, 8'd4, 8'd3};
    tick(); tick();
    rst = 1'b0;
    check("rst_credit", credit, 0);
    check("rst_vend_valid", vend_valid, 0);
    check("rst_chg_valid", chg_valid, 0);
    check("rst_busy", busy, 0);

    // Exact-credit vend, no change
    coin(2'b10); coin(2'b01);
    check("t1_credit", credit, 3);
    select(2'd0);
    check("t1_vend_valid", vend_valid, 1);
    check("t1_vend_id", vend_id, 0);
    check("t1_credit_after", credit, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_vend_hold", vend_valid, 1);
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;
    check("t1_vend_drop", vend_valid, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_no_change", chg_valid, 0);
    tick();
    check("t1_no_change2", chg_valid, 0);

    // Vend with Rs.10 change, hopper stalls
    coin(2'b11); coin(2'b11);
    check("t2_credit", credit, 8);
    select(2'd2);
    check("t2_credit_after", credit, 2);
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;
    check("t2_chg_valid", chg_valid, 1);
    check("t2_chg_coin", chg_coin, 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", chg_valid, 1);
      check("t2_stall_coin", chg_coin, 2'b10);
    end
    chg_ready = 1'b1; tick(); chg_ready = 1'b0;
    check("t2_done_valid", chg_valid, 0);
    check("t2_done_credit", credit, 0);
    check("t2_done_busy", busy, 0);

    // Cancel refund 7 -> 20, 10, 5
    coin(2'b01); coin(2'b10); coin(2'b11);
    check("t3_credit", credit, 7);
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("t3_coin_a", chg_coin, 2'b11);
    check("t3_valid_a", chg_valid, 1);
    chg_ready = 1'b1;
    tick();
    check("t3_credit_b", credit, 3);
    check("t3_coin_b", chg_coin, 2'b10);
    tick();
    check("t3_credit_c", credit, 1);
    check("t3_coin_c", chg_coin, 2'b01);
    tick();
    chg_ready = 1'b0;
    check("t3_credit_end", credit, 0);
    check("t3_valid_end", chg_valid, 0);
    check("t3_busy_end", busy, 0);

    // Denied selection, then affordable one
    coin(2'b10);
    select(2'd1);
    check("t4_denied", sel_denied, 1);
    check("t4_credit", credit, 2);
    check("t4_no_vend", vend_valid, 0);
    tick();
    check("t4_denied_pulse", sel_denied, 0);
    select(2'd3);
    check("t4_vend_valid", vend_valid, 1);
    check("t4_vend_id", vend_id, 3);
    check("t4_credit_after", credit, 0);
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;
    check("t4_idle", busy, 0);

    // Credit ceiling and invalid coin
    for (int i = 0; i < 9; i++) coin(2'b11);
    coin(2'b10);
    check("t5_credit38", credit, 38);
    coin(2'b11);
    check("t5_reject20", coin_reject, 1);
    check("t5_credit_kept", credit, 38);
    coin(2'b10);
    check("t5_credit40", credit, 40);
    check("t5_accept10", coin_reject, 0);
    coin(2'b00);
    check("t5_reject_bad", coin_reject, 1);
    check("t5_credit_still40", credit, 40);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chg_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chg_ready = 1'b0;
    check("t5_flushed_credit", credit, 0);
    check("t5_flushed_valid", chg_valid, 0);

    // Free vend: price sampled only at the selection cycle
    prices = {8'd0, 8'd6, 8'd4, 8'd3};
    select(2'd3);
    prices = {8'd2, 8'd6, 8'd4, 8'd3};
    check("t6_free_vend", vend_valid, 1);
    check("t6_free_credit", credit, 0);
    vend_ready = 1'b1; tick(); vend_ready = 1'b0;

    // Simultaneous cancel/select/coin, then reset mid-change
    coin(2'b11); coin(2'b01);
    check("t7_credit", credit, 5);
    cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; coin_valid = 1'b1; coin_val = 2'b01;
    tick();
    cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0;
    check("t7_reject", coin_reject, 1);
    check("t7_no_vend", vend_valid, 0);
    check("t7_chg_valid", chg_valid, 1);
    check("t7_chg_coin", chg_coin, 2'b11);
    check("t7_credit_kept", credit, 5);
    coin_valid = 1'b1; coin_val = 2'b10; sel_valid = 1'b1;
    tick();
    coin_valid = 1'b0; sel_valid = 1'b0;
    check("t7_busy_reject", coin_reject, 1);
    check("t7_busy_denied", sel_denied, 1);
    check("t7_busy_credit", credit, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t7_rst_chg_valid", chg_valid, 0);
    check("t7_rst_chg_coin", chg_coin, 0);
    check("t7_rst_credit", credit, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_reject", coin_reject, 0);
    check("t7_rst_denied", sel_denied, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
